// File: rtl/spi_frame_integrity_checker.sv
// ---------------------------------------------------------------------------
// spi_frame_integrity_checker
//
// Passive SPI bus monitor. Deserialises PICO and POCI (MSB first) into
// BUS_LENGTH-bit words on externally supplied sample_tick strobes and
// checks every completed word against an integrity rule selected by
// chk_mode. The rule is latched at the start of each frame. Frames end on
// cs_rise. The block keeps per-frame word indexing, sticky error flags and a
// saturating error counter. It never drives the bus.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active low
//   sample_tick  one-cycle strobe: sample PICO/POCI now
//   cs_rise      one-cycle strobe: frame end (CS deasserted)
//   PICO, POCI   SPI data lines being monitored
//   chk_mode     0 parity match, 1 word echo, 2 embedded parity on PICO,
//                3 embedded parity on both lines
//   clr_err      clears parity_err, frag_err, ovf_err and err_count
//   word_valid   one-cycle pulse: word completed
//   word_pico    last completed PICO word
//   word_poci    last completed POCI word
//   word_idx     index of the completed word within its frame
//   word_err     one-cycle pulse with word_valid when the check fails
//   parity_err   sticky: any word_err since reset/clear
//   frag_err     sticky: a frame ended mid-word
//   ovf_err      sticky: more than MAX_WORDS words in one frame
//   err_count    saturating count of word errors plus fragment events
//   frame_done   one-cycle pulse after cs_rise
//   frame_words  completed words in the frame just ended (saturates)
//
// state  | meaning
// IDLE   | no frame in progress, waiting for the first sample_tick
// ACTIVE | frame in progress, chk_mode latched
// ---------------------------------------------------------------------------
module spi_frame_integrity_checker #(
  parameter int BUS_LENGTH = 8,
  parameter int MAX_WORDS  = 4,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8,
  localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
  localparam int CNT_W     = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  cs_rise,
  input  logic                  PICO,
  input  logic                  POCI,
  input  logic [1:0]            chk_mode,
  input  logic                  clr_err,
  output logic                  word_valid,
  output logic [BUS_LENGTH-1:0] word_pico,
  output logic [BUS_LENGTH-1:0] word_poci,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  word_err,
  output logic                  parity_err,
  output logic                  frag_err,
  output logic                  ovf_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_words
);

  localparam int  BCNT_W  = $clog2(BUS_LENGTH);
  localparam bit  ODD_BIT = (ODD_PARITY != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state, state_n;
  logic [1:0]            mode_q, mode_n;
  logic [BUS_LENGTH-1:0] sh_pico, sh_pico_n, sh_poci, sh_poci_n;
  logic [BCNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0]      word_cnt, word_cnt_n;

  logic                  word_valid_n, word_err_n, frame_done_n;
  logic [BUS_LENGTH-1:0] word_pico_n, word_poci_n;
  logic [IDX_W-1:0]      word_idx_n;
  logic                  parity_err_n, frag_err_n, ovf_err_n;
  logic [ERR_CNT_W-1:0]  err_count_n;
  logic [CNT_W-1:0]      frame_words_n;

  // scratch values for the current cycle
  logic [BUS_LENGTH-1:0] pico_w, poci_w;
  logic [BCNT_W-1:0]     bit_after;
  logic [CNT_W-1:0]      cnt_after;
  logic                  frag_n, ovf_n;
  logic [ERR_CNT_W-1:0]  cnt_base;

  // Embedded-parity rule: LSB must equal parity of the upper bits (XOR ODD_BIT)
  function automatic logic emb_fail(input logic [BUS_LENGTH-1:0] w);
    return (^w[BUS_LENGTH-1:1]) ^ ODD_BIT ^ w[0];
  endfunction

  always_comb begin
    state_n       = state;
    mode_n        = mode_q;
    sh_pico_n     = sh_pico;
    sh_poci_n     = sh_poci;
    word_valid_n  = 1'b0;
    word_err_n    = 1'b0;
    frame_done_n  = 1'b0;
    word_pico_n   = word_pico;
    word_poci_n   = word_poci;
    word_idx_n    = word_idx;
    frame_words_n = frame_words;
    frag_n        = 1'b0;
    ovf_n         = 1'b0;
    pico_w        = {sh_pico[BUS_LENGTH-2:0], PICO};
    poci_w        = {sh_poci[BUS_LENGTH-2:0], POCI};
    bit_after     = bit_cnt;
    cnt_after     = word_cnt;

    // A tick coinciding with cs_rise belongs to the ending frame, so it is
    // applied first and the frame-end logic below sees its effect.
    if (sample_tick) begin
      sh_pico_n = pico_w;
      sh_poci_n = poci_w;
      if (state == IDLE) begin
        state_n = ACTIVE;
        mode_n  = chk_mode;
      end
      if (bit_cnt == BCNT_W'(BUS_LENGTH - 1)) begin
        bit_after    = '0;
        word_valid_n = 1'b1;
        word_pico_n  = pico_w;
        word_poci_n  = poci_w;
        if (word_cnt == CNT_W'(MAX_WORDS)) begin
          ovf_n      = 1'b1;
          word_idx_n = IDX_W'(MAX_WORDS - 1);
        end else begin
          word_idx_n = word_cnt[IDX_W-1:0];
          cnt_after  = word_cnt + 1'b1;
        end
        case (mode_n)
          2'd0:    word_err_n = (^pico_w) != (^poci_w);
          2'd1:    word_err_n = pico_w != poci_w;
          2'd2:    word_err_n = emb_fail(pico_w);
          default: word_err_n = emb_fail(pico_w) | emb_fail(poci_w);
        endcase
      end else begin
        bit_after = bit_cnt + 1'b1;
      end
    end

    bit_cnt_n  = bit_after;
    word_cnt_n = cnt_after;

    if (cs_rise) begin
      frame_done_n  = 1'b1;
      frame_words_n = cnt_after;
      frag_n        = (bit_after != '0);
      bit_cnt_n     = '0;
      word_cnt_n    = '0;
      sh_pico_n     = '0;
      sh_poci_n     = '0;
      state_n       = IDLE;
    end

    // clr_err drops old history; an error arriving in the same cycle survives
    parity_err_n = (parity_err & ~clr_err) | word_err_n;
    frag_err_n   = (frag_err   & ~clr_err) | frag_n;
    ovf_err_n    = (ovf_err    & ~clr_err) | ovf_n;
    cnt_base     = clr_err ? '0 : err_count;
    // word errors and fragments are mutually exclusive in one cycle
    if ((word_err_n || frag_n) && (cnt_base != {ERR_CNT_W{1'b1}}))
      err_count_n = cnt_base + 1'b1;
    else
      err_count_n = cnt_base;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      mode_q      <= '0;
      sh_pico     <= '0;
      sh_poci     <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      word_valid  <= 1'b0;
      word_err    <= 1'b0;
      word_pico   <= '0;
      word_poci   <= '0;
      word_idx    <= '0;
      parity_err  <= 1'b0;
      frag_err    <= 1'b0;
      ovf_err     <= 1'b0;
      err_count   <= '0;
      frame_done  <= 1'b0;
      frame_words <= '0;
    end else begin
      state       <= state_n;
      mode_q      <= mode_n;
      sh_pico     <= sh_pico_n;
      sh_poci     <= sh_poci_n;
      bit_cnt     <= bit_cnt_n;
      word_cnt    <= word_cnt_n;
      word_valid  <= word_valid_n;
      word_err    <= word_err_n;
      word_pico   <= word_pico_n;
      word_poci   <= word_poci_n;
      word_idx    <= word_idx_n;
      parity_err  <= parity_err_n;
      frag_err    <= frag_err_n;
      ovf_err     <= ovf_err_n;
      err_count   <= err_count_n;
      frame_done  <= frame_done_n;
      frame_words <= frame_words_n;
    end
  end

endmodule

// File: tb/tb_spi_frame_integrity_checker.sv
module tb_spi_frame_integrity_checker;
  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_tick = 1'b0, cs_rise = 1'b0, PICO = 1'b0, POCI = 1'b0, clr_err = 1'b0;
  logic [1:0] chk_mode = 2'd0;

  logic       word_valid, word_err, parity_err, frag_err, ovf_err, frame_done;
  logic [7:0] word_pico, word_poci, err_count;
  logic [1:0] word_idx;
  logic [2:0] frame_words;

  logic       s_word_valid, s_word_err, s_parity_err, s_frag_err, s_ovf_err, s_frame_done;
  logic [7:0] s_word_pico, s_word_poci;
  logic [1:0] s_err_count;
  logic [1:0] s_word_idx;
  logic [2:0] s_frame_words;

  spi_frame_integrity_checker #(.BUS_LENGTH(8), .MAX_WORDS(4), .ODD_PARITY(0), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .cs_rise(cs_rise), .PICO(PICO), .POCI(POCI),
    .chk_mode(chk_mode), .clr_err(clr_err), .word_valid(word_valid), .word_pico(word_pico),
    .word_poci(word_poci), .word_idx(word_idx), .word_err(word_err), .parity_err(parity_err),
    .frag_err(frag_err), .ovf_err(ovf_err), .err_count(err_count), .frame_done(frame_done),
    .frame_words(frame_words));

  spi_frame_integrity_checker #(.BUS_LENGTH(8), .MAX_WORDS(4), .ODD_PARITY(0), .ERR_CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .cs_rise(cs_rise), .PICO(PICO), .POCI(POCI),
    .chk_mode(chk_mode), .clr_err(clr_err), .word_valid(s_word_valid), .word_pico(s_word_pico),
    .word_poci(s_word_poci), .word_idx(s_word_idx), .word_err(s_word_err), .parity_err(s_parity_err),
    .frag_err(s_frag_err), .ovf_err(s_ovf_err), .err_count(s_err_count), .frame_done(s_frame_done),
    .frame_words(s_frame_words));

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int n_wv, n_werr, last_idx, exp_cnt;
  logic [3:0] err_mask;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] pico;
    logic [7:0] poci;
    logic       err;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // apply one cycle of inputs; outputs registered at that edge are then visible
  task automatic cyc(input logic t, input logic c, input logic p, input logic q, input logic cl);
    sample_tick = t; cs_rise = c; PICO = p; POCI = q; clr_err = cl;
    @(posedge clk);
    #1;
    if (word_valid) begin
      n_wv++;
      last_idx = int'(word_idx);
      if (word_err) begin
        n_werr++;
        err_mask[word_idx] = 1'b1;
      end
    end
    @(negedge clk);
    sample_tick = 1'b0; cs_rise = 1'b0; clr_err = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] p, input logic [7:0] q,
                           input logic cs_last = 1'b0, input logic cl_last = 1'b0);
    for (int i = BL - 1; i >= 0; i--)
      cyc(1'b1, (i == 0) && cs_last, p[i], q[i], (i == 0) && cl_last);
  endtask

  task automatic reset_stats();
    n_wv = 0; n_werr = 0; err_mask = 4'b0; last_idx = -1;
  endtask

  task automatic clear_errors();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_cnt = 0;
  endtask

  function automatic logic [63:0] all_outs();
    return {29'b0, word_valid, word_pico, word_poci, word_idx, word_err, parity_err,
            frag_err, ovf_err, err_count, frame_done, frame_words};
  endfunction

  initial begin
    logic [7:0] p, q;

    vecs[0] = '{2'd0, 8'hA5, 8'h5A, 1'b0};
    vecs[1] = '{2'd1, 8'hC3, 8'hC3, 1'b0};
    vecs[2] = '{2'd1, 8'hE3, 8'hC3, 1'b1};
    vecs[3] = '{2'd2, 8'hB7, 8'h00, 1'b0};
    vecs[4] = '{2'd2, 8'hB6, 8'h00, 1'b1};
    vecs[5] = '{2'd3, 8'hB7, 8'hB7, 1'b0};
    vecs[6] = '{2'd3, 8'hB7, 8'hB6, 1'b1};
    vecs[7] = '{2'd0, 8'h01, 8'h00, 1'b1};
    reset_stats();
    exp_cnt = 0;

    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // table-driven single-word frames
    for (int v = 0; v < 8; v++) begin
      chk_mode = vecs[v].mode;
      reset_stats();
      send_word(vecs[v].pico, vecs[v].poci);
      check($sformatf("v%0d_word_valid", v), word_valid, 1);
      check($sformatf("v%0d_word_pico", v), word_pico, vecs[v].pico);
      check($sformatf("v%0d_word_poci", v), word_poci, vecs[v].poci);
      check($sformatf("v%0d_word_err", v), word_err, vecs[v].err);
      check($sformatf("v%0d_word_idx", v), word_idx, 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (vecs[v].err) exp_cnt++;
      check($sformatf("v%0d_frame_done", v), frame_done, 1);
      check($sformatf("v%0d_frame_words", v), frame_words, 1);
      check($sformatf("v%0d_n_word_valid", v), n_wv, 1);
      check($sformatf("v%0d_err_count", v), err_count, exp_cnt);
      check($sformatf("v%0d_parity_err", v), parity_err, exp_cnt != 0);
    end

    clear_errors();
    check("clr_err_count", err_count, 0);
    check("clr_parity_err", parity_err, 0);
    check("clr_small_count", s_err_count, 0);

    // mode is latched on the first tick: echo mismatch, but equal parity
    p = 8'h0F; q = 8'hF0;
    chk_mode = 2'd1;
    cyc(1'b1, 1'b0, p[7], q[7], 1'b0);
    chk_mode = 2'd0;
    for (int i = 6; i >= 0; i--) cyc(1'b1, 1'b0, p[i], q[i], 1'b0);
    check("latched_mode_err", word_err, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    clear_errors();

    // four-word frame, parity mismatch on the last word only
    chk_mode = 2'd0;
    reset_stats();
    send_word(8'h11, 8'hAA);
    send_word(8'h22, 8'hBB);
    send_word(8'h33, 8'hCC);
    send_word(8'h44, 8'hDC);
    check("multi_err_mask", err_mask, 4'b1000);
    check("multi_n_valid", n_wv, 4);
    check("multi_no_ovf", ovf_err, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("multi_frame_words", frame_words, 4);
    check("multi_err_count", err_count, 1);
    check("multi_parity_err", parity_err, 1);
    clear_errors();

    // fragment: frame ends after five ticks
    reset_stats();
    repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("frag_frame_done", frame_done, 1);
    check("frag_frame_words", frame_words, 0);
    check("frag_err", frag_err, 1);
    check("frag_err_count", err_count, 1);
    check("frag_no_valid", n_wv, 0);
    clear_errors();
    check("frag_cleared", frag_err, 0);

    // overflow: six words in one frame with MAX_WORDS=4
    chk_mode = 2'd1;
    reset_stats();
    for (int w = 0; w < 6; w++) begin
      send_word(8'h10 + 8'(w), 8'h10 + 8'(w));
      if (w == 3) check("ovf_not_yet", ovf_err, 0);
      if (w == 4) check("ovf_set", ovf_err, 1);
    end
    check("ovf_n_valid", n_wv, 6);
    check("ovf_last_idx", last_idx, 3);
    check("ovf_last_pico", word_pico, 8'h15);
    check("ovf_no_word_err", n_werr, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovf_frame_words", frame_words, 4);
    clear_errors();
    check("ovf_cleared", ovf_err, 0);

    // completing tick and cs_rise in the same cycle
    chk_mode = 2'd0;
    reset_stats();
    send_word(8'h3C, 8'h3C, 1'b1, 1'b0);
    check("same_cyc_valid", word_valid, 1);
    check("same_cyc_done", frame_done, 1);
    check("same_cyc_frame_words", frame_words, 1);
    check("same_cyc_no_frag", frag_err, 0);
    check("same_cyc_pico", word_pico, 8'h3C);

    // clr_err together with a new word error: new error wins
    chk_mode = 2'd1;
    send_word(8'h00, 8'hFF);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_clr_count", err_count, 1);
    send_word(8'h01, 8'h00, 1'b0, 1'b1);
    check("clr_collide_count", err_count, 1);
    check("clr_collide_flag", parity_err, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    clear_errors();

    // saturation of a 2-bit counter after five errors
    chk_mode = 2'd1;
    for (int e = 0; e < 5; e++) begin
      send_word(8'h00, 8'hFF);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("sat_wide_count", err_count, 5);
    check("sat_small_count", s_err_count, 3);

    // reset mid-word, cs_rise arriving during reset is ignored
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_no_done", frame_done, 0);
    check("midrst_no_valid", word_valid, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst_done_after", frame_done, 1);
    check("midrst_no_frag", frag_err, 0);
    check("midrst_frame_words", frame_words, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
